rf_writeback: RTL and testbench



---
 rtl/rf_writeback_if.sv | 38 +++
 rtl/rf_writeback.sv | 126 ++++++++++++
 tb/tb_rf_writeback.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_if.sv
// Bundle between execute/memory stages, rf_writeback and the register file.
// Ports: ALU result handshake, load return, load issue, RF write port, scoreboard, buffer fill.
interface rf_writeback_if #(
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          alu_valid;
  logic [3:0]    alu_rd;
  logic [15:0]   alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [3:0]    mem_rd;
  logic [15:0]   mem_data;
  logic          ld_issue;
  logic [3:0]    ld_rd;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [15:0]   wr_data;
  logic [15:0]   busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output ld_issue, ld_rd,
    input  alu_ready, wr_en, wr_addr, wr_data,
    input  busy, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  ld_issue, ld_rd,
    output alu_ready, wr_en, wr_addr, wr_data,
    output busy, fifo_count
  );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write arbiter: load returns beat buffered ALU results, which beat bypass.
// Ports: clk, rst (sync, active-high), bus (rf_writeback_if.slave).
module rf_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input logic            clk,
  input logic            rst,
  rf_writeback_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;

  ent_t          fifo [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          wr_en_q;
  logic [3:0]    wr_addr_q;
  logic [15:0]   wr_data_q;
  logic [15:0]   busy_q;

  logic          ready;
  logic          acc;
  logic          fifo_ne;
  logic          sel_mem;
  logic          sel_fifo;
  logic          sel_byp;
  logic          pop;
  logic          push;
  logic          win;
  logic [3:0]    win_rd;
  logic [15:0]   win_data;
  logic [15:0]   clr;
  logic [15:0]   set;
  logic [15:0]   busy_nxt;
  ent_t          head;

  assign ready   = (count < CW'(FIFO_DEPTH));
  assign acc     = bus.alu_valid && ready;
  assign fifo_ne = (count != '0);
  assign head    = fifo[rd_ptr];

  // one-hot select so the decoder below stays unique
  assign sel_mem  = bus.mem_valid;
  assign sel_fifo = !bus.mem_valid && fifo_ne;
  assign sel_byp  = !bus.mem_valid && !fifo_ne && acc;

  // an accepted result that did not win must queue behind older ones
  assign push = acc && !sel_byp;
  assign pop  = sel_fifo;

  always_comb begin
    win      = 1'b1;
    win_rd   = bus.mem_rd;
    win_data = bus.mem_data;
    unique case (1'b1)
      sel_mem: begin
        win_rd   = bus.mem_rd;
        win_data = bus.mem_data;
      end
      sel_fifo: begin
        win_rd   = head.rd;
        win_data = head.data;
      end
      sel_byp: begin
        win_rd   = bus.alu_rd;
        win_data = bus.alu_data;
      end
      default: win = 1'b0;
    endcase
  end

  // set applied after clear: a same-index issue keeps the bit
  assign clr = bus.mem_valid ? (16'h0001 << bus.mem_rd) : 16'h0000;
  assign set = bus.ld_issue ? (16'h0001 << bus.ld_rd) : 16'h0000;
  assign busy_nxt = (busy_q & ~clr) | set;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{rd: bus.alu_rd, data: bus.alu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      wr_en_q <= win;
      if (win) begin
        wr_addr_q <= win_rd;
        wr_data_q <= win_data;
      end
      busy_q <= busy_nxt;
    end
  end

  assign bus.alu_ready  = ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_rf_writeback;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  rf_writeback_if #(.FIFO_DEPTH(DEPTH)) bus ();

  rf_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(
    input logic        av,
    input logic [3:0]  ar,
    input logic [15:0] ad,
    input logic        mv,
    input logic [3:0]  mr,
    input logic [15:0] md,
    input logic        li,
    input logic [3:0]  lr
  );
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mr;
    bus.mem_data  = md;
    bus.ld_issue  = li;
    bus.ld_rd     = lr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'h0 ||
        bus.wr_data !== 16'h0)
      $display("FAIL reset_wr: en=%b addr=%h data=%h want 0/0/0",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 16'h0 || bus.fifo_count !== CW'(0))
      $display("FAIL reset_state: busy=%h cnt=%0d want 0/0",
               bus.busy, bus.fifo_count);
    else n_pass++;
    n_chk++;
    if (bus.alu_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", bus.alu_ready);
    else n_pass++;
  endtask

  task automatic test_alu_only();
    do_reset();
    drv(1, 3, 16'h1234, 0, 0, 0, 0, 0);
    tick();
    idle();
    n_chk++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd3 ||
        bus.wr_data !== 16'h1234 || bus.fifo_count !== CW'(0))
      $display("FAIL alu_bypass: en=%b a=%h d=%h c=%0d want 1/3/1234/0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.fifo_count);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'd3 ||
        bus.wr_data !== 16'h1234)
      $display("FAIL alu_hold: en=%b a=%h d=%h want 0/3/1234",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    drv(1, 6, 16'h5555, 1, 5, 16'hAAAA, 0, 0);
    tick();
    idle();
    n_chk++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd5 ||
        bus.wr_data !== 16'hAAAA || bus.fifo_count !== CW'(1))
      $display("FAIL coll_mem: en=%b a=%h d=%h c=%0d want 1/5/aaaa/1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.fifo_count);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd6 ||
        bus.wr_data !== 16'h5555 || bus.fifo_count !== CW'(0))
      $display("FAIL coll_alu: en=%b a=%h d=%h c=%0d want 1/6/5555/0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.fifo_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0] rds [4] = '{4'd1, 4'd2, 4'd3, 4'd3};
    logic       rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1, rds[i], 16'h1000 + 16'(rds[i]),
          1, 4'(8 + i), 16'hB000 + 16'(i), 0, 0);
      n_chk++;
      if (bus.alu_ready !== rdy[i])
        $display("FAIL bp_ready%0d: got %b want %b", i, bus.alu_ready, rdy[i]);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'(8 + i) ||
          bus.wr_data !== 16'hB000 + 16'(i))
        $display("FAIL bp_mem%0d: en=%b a=%h d=%h want 1/%h/%h", i,
                 bus.wr_en, bus.wr_addr, bus.wr_data, 4'(8 + i),
                 16'hB000 + 16'(i));
      else n_pass++;
    end
    idle();
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'(i) ||
          bus.wr_data !== 16'h1000 + 16'(i))
        $display("FAIL bp_drain%0d: en=%b a=%h d=%h want 1/%h/%h", i,
                 bus.wr_en, bus.wr_addr, bus.wr_data, 4'(i), 16'h1000 + 16'(i));
      else n_pass++;
    end
    tick();
    n_chk++;
    if (bus.wr_en !== 1'b0 || bus.fifo_count !== CW'(0))
      $display("FAIL bp_empty: en=%b c=%0d want 0/0", bus.wr_en, bus.fifo_count);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    n_chk++;
    if (bus.busy !== 16'h0080)
      $display("FAIL sb_set: busy=%h want 0080", bus.busy);
    else n_pass++;
    drv(0, 0, 0, 1, 7, 16'h7777, 1, 7);
    tick();
    n_chk++;
    if (bus.busy !== 16'h0080)
      $display("FAIL sb_setwins: busy=%h want 0080", bus.busy);
    else n_pass++;
    drv(0, 0, 0, 1, 7, 16'h7778, 0, 0);
    tick();
    n_chk++;
    if (bus.busy !== 16'h0000)
      $display("FAIL sb_clear: busy=%h want 0000", bus.busy);
    else n_pass++;
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    drv(0, 0, 0, 1, 0, 16'h0, 0, 0);
    tick();
    idle();
    n_chk++;
    if (bus.busy !== 16'h0000)
      $display("FAIL sb_double: busy=%h want 0000", bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drv(1, 9, 16'h0909, 1, 0, 16'h0A0A, 1, 0);
    tick();
    drv(1, 10, 16'h1010, 1, 1, 16'h0B0B, 1, 4);
    tick();
    n_chk++;
    if (bus.fifo_count !== CW'(2) || bus.busy !== 16'h0011 ||
        bus.wr_en !== 1'b1)
      $display("FAIL rm_pre: c=%0d busy=%h en=%b want 2/0011/1",
               bus.fifo_count, bus.busy, bus.wr_en);
    else n_pass++;
    drv(1, 11, 16'h1111, 0, 0, 0, 1, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_chk++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'h0 ||
        bus.wr_data !== 16'h0 || bus.busy !== 16'h0 ||
        bus.fifo_count !== CW'(0) || bus.alu_ready !== 1'b1)
      $display("FAIL rm_post: en=%b a=%h d=%h busy=%h c=%0d rdy=%b",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy,
               bus.fifo_count, bus.alu_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b0)
        $display("FAIL rm_stale%0d: en=%b want 0", i, bus.wr_en);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [15:0] m_busy;
    logic        m_en;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    logic        av, mv, li, acc, byp;
    logic [3:0]  ar, mr, lr;
    logic [15:0] ad, md;
    do_reset();
    m_busy = 0;
    m_en   = 0;
    m_addr = 0;
    m_data = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      av = ($urandom_range(99) < 60);
      mv = ($urandom_range(99) < (cyc < 300 ? 40 : 70));
      li = ($urandom_range(99) < 30);
      ar = 4'($urandom);
      mr = 4'($urandom);
      lr = 4'($urandom);
      ad = 16'($urandom);
      md = 16'($urandom);
      rst = ($urandom_range(99) < 2);
      drv(av, ar, ad, mv, mr, md, li, lr);
      n_chk++;
      if (bus.alu_ready !== (q.size() < DEPTH))
        $display("FAIL rnd_ready c%0d: got %b want %b", cyc,
                 bus.alu_ready, q.size() < DEPTH);
      else n_pass++;
      acc = av && (q.size() < DEPTH);
      byp = 1'b0;
      if (rst) begin
        q.delete();
        m_busy = 0;
        m_en = 0;
        m_addr = 0;
        m_data = 0;
      end else begin
        m_en = 1'b1;
        if (mv) begin
          m_addr = mr;
          m_data = md;
        end else if (q.size() > 0) begin
          e = q.pop_front();
          m_addr = e.rd;
          m_data = e.d;
        end else if (acc) begin
          m_addr = ar;
          m_data = ad;
          byp = 1'b1;
        end else begin
          m_en = 1'b0;
        end
        if (acc && !byp) q.push_back('{rd: ar, d: ad});
        if (mv) m_busy[mr] = 1'b0;
        if (li) m_busy[lr] = 1'b1;
      end
      tick();
      rst = 1'b0;
      n_chk++;
      if (bus.wr_en !== m_en || bus.wr_addr !== m_addr ||
          bus.wr_data !== m_data)
        $display("FAIL rnd_wr c%0d: en=%b a=%h d=%h want %b/%h/%h", cyc,
                 bus.wr_en, bus.wr_addr, bus.wr_data, m_en, m_addr, m_data);
      else n_pass++;
      n_chk++;
      if (bus.busy !== m_busy)
        $display("FAIL rnd_busy c%0d: got %h want %h", cyc, bus.busy, m_busy);
      else n_pass++;
      n_chk++;
      if (bus.fifo_count !== CW'(q.size()))
        $display("FAIL rnd_count c%0d: got %0d want %0d", cyc,
                 bus.fifo_count, q.size());
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_only();
    test_collision();
    test_backpressure();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
